// File: rtl/fetcher_icache.sv
// Instruction fetch stage with a direct-mapped cache of one instruction per line: hits reach FETCHED one
// cycle after FETCH; misses hold a valid/ready read until ready; FETCHED holds until the core reaches DECODE.
module fetcher_icache #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int CACHE_LINES           = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [15:0]                      hit_count,
  output logic [15:0]                      miss_count
);
  localparam int IDX_BITS = $clog2(CACHE_LINES);
  localparam int TAG_BITS = PROGRAM_MEM_ADDR_BITS - IDX_BITS;

  localparam logic [2:0] S_IDLE      = 3'b000;
  localparam logic [2:0] S_FETCHING  = 3'b001;
  localparam logic [2:0] S_FETCHED   = 3'b010;
  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

  logic [2:0]                       r_state;
  logic                             r_mem_vld;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] r_mem_addr;
  logic [PROGRAM_MEM_DATA_BITS-1:0] r_instr;
  logic [15:0]                      r_hit_cnt;
  logic [15:0]                      r_miss_cnt;
  logic                             r_flush_pending;
  logic [CACHE_LINES-1:0]           r_valid;
  logic [TAG_BITS-1:0]              r_tag  [CACHE_LINES];
  logic [PROGRAM_MEM_DATA_BITS-1:0] r_data [CACHE_LINES];

  logic [IDX_BITS-1:0] w_idx;
  logic [TAG_BITS-1:0] w_tag;
  logic [IDX_BITS-1:0] w_fill_idx;
  logic [TAG_BITS-1:0] w_fill_tag;
  logic                w_lookup;
  logic                w_hit;
  logic                w_fill_done;
  logic                w_fill_we;

  assign w_idx       = current_pc[IDX_BITS-1:0];
  assign w_tag       = current_pc[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS];
  assign w_fill_idx  = r_mem_addr[IDX_BITS-1:0];
  assign w_fill_tag  = r_mem_addr[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS];
  assign w_lookup    = (r_state == S_IDLE) && (core_state == CORE_FETCH);
  // A flush in the lookup cycle forces a miss so stale kernel code is never returned.
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag) && !flush;
  assign w_fill_done = (r_state == S_FETCHING) && mem_read_ready;
  assign w_fill_we   = w_fill_done && !flush && !r_flush_pending;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= '0;
    end else if (flush) begin
      r_valid <= '0;
    end else if (w_fill_we) begin
      r_valid[w_fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && w_fill_we) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= mem_read_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_mem_vld       <= 1'b0;
      r_mem_addr      <= '0;
      r_instr         <= '0;
      r_hit_cnt       <= '0;
      r_miss_cnt      <= '0;
      r_flush_pending <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_lookup) begin
            if (w_hit) begin
              r_instr <= r_data[w_idx];
              r_state <= S_FETCHED;
              if (r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
            end else begin
              r_mem_vld       <= 1'b1;
              r_mem_addr      <= current_pc;
              r_state         <= S_FETCHING;
              r_flush_pending <= flush;
              if (r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
            end
          end
        end
        S_FETCHING: begin
          if (mem_read_ready) begin
            r_mem_vld       <= 1'b0;
            r_instr         <= mem_read_data;
            r_state         <= S_FETCHED;
            r_flush_pending <= 1'b0;
          end else if (flush) begin
            r_flush_pending <= 1'b1;
          end
        end
        S_FETCHED: begin
          if (core_state == CORE_DECODE) r_state <= S_IDLE;
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_vld <= 1'b0;
        end
      endcase
    end
  end

  assign mem_read_valid   = r_mem_vld;
  assign mem_read_address = r_mem_addr;
  assign fetcher_state    = r_state;
  assign instruction      = r_instr;
  assign hit_count        = r_hit_cnt;
  assign miss_count       = r_miss_cnt;
endmodule

// File: tb/tb_fetcher_icache.sv
// Bench for fetcher_icache: directed vector table, reset and saturation sequences, and random fetches
// checked against a transaction-level cache model.
module tb_fetcher_icache;
  localparam int LINES = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  core_state;
  logic [7:0]  current_pc;
  logic        flush;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetcher_icache #(
    .PROGRAM_MEM_ADDR_BITS(8),
    .PROGRAM_MEM_DATA_BITS(16),
    .CACHE_LINES(LINES)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .core_state       (core_state),
    .current_pc       (current_pc),
    .flush            (flush),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .fetcher_state    (fetcher_state),
    .instruction      (instruction),
    .hit_count        (hit_count),
    .miss_count       (miss_count)
  );

  typedef struct {
    logic [7:0]  pc;
    int          lat;
    logic [15:0] rdata;
    int          flush_at;
    logic        exp_miss;
    logic [15:0] exp_instr;
    logic [15:0] exp_hits;
    logic [15:0] exp_misses;
  } vec_t;

  vec_t tbl[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // flush_at: -1 none, 0 in the lookup cycle, k in the k-th cycle the request is outstanding.
  task automatic run_fetch(input logic [7:0] pc, input int lat, input logic [15:0] rdata,
                           input int flush_at, output logic missed, output logic [15:0] instr);
    int held;
    held       = 0;
    core_state = 3'b001;
    current_pc = pc;
    flush      = (flush_at == 0);
    tick();
    flush  = 1'b0;
    missed = (fetcher_state == 3'b001);
    if (missed) begin
      for (int s = 1; s <= lat; s++) begin
        if (mem_read_valid && mem_read_address == pc) held++;
        mem_read_ready = (s == lat);
        mem_read_data  = (s == lat) ? rdata : 16'hDEAD;
        flush          = (flush_at == s);
        tick();
      end
      mem_read_ready = 1'b0;
      flush          = 1'b0;
      chk("req_held_cycles", 32'(held), 32'(lat));
    end
    chk("fetched_state", 32'(fetcher_state), 32'(3'b010));
    chk("mem_valid_low", 32'(mem_read_valid), 32'd0);
    instr = instruction;
    // Stray ready while FETCHED must not disturb the held instruction.
    mem_read_ready = 1'b1;
    mem_read_data  = ~instr;
    tick();
    mem_read_ready = 1'b0;
    chk("fetched_hold_state", 32'(fetcher_state), 32'(3'b010));
    chk("fetched_hold_instr", 32'(instruction), 32'(instr));
    core_state = 3'b010;
    tick();
    chk("return_idle", 32'(fetcher_state), 32'd0);
    core_state = 3'b000;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  logic        m_valid [LINES];
  logic [4:0]  m_tag   [LINES];
  logic [15:0] img     [256];

  initial begin
    logic        missed;
    logic [15:0] instr;
    logic [15:0] eh, em;

    tbl[0]  = '{8'h05, 3, 16'hA1B2,  -1, 1'b1, 16'hA1B2, 16'd0, 16'd1};
    tbl[1]  = '{8'h05, 1, 16'hA1B2,  -1, 1'b0, 16'hA1B2, 16'd1, 16'd1};
    tbl[2]  = '{8'h0D, 2, 16'h7777,  -1, 1'b1, 16'h7777, 16'd1, 16'd2};
    tbl[3]  = '{8'h05, 1, 16'hA1B2,  -1, 1'b1, 16'hA1B2, 16'd1, 16'd3};
    tbl[4]  = '{8'h10, 3, 16'h1234,   2, 1'b1, 16'h1234, 16'd1, 16'd4};
    tbl[5]  = '{8'h10, 2, 16'h1234,  -1, 1'b1, 16'h1234, 16'd1, 16'd5};
    tbl[6]  = '{8'h10, 1, 16'h1234,  -1, 1'b0, 16'h1234, 16'd2, 16'd5};
    tbl[7]  = '{8'h05, 1, 16'hA1B2,  -1, 1'b1, 16'hA1B2, 16'd2, 16'd6};
    tbl[8]  = '{8'h22, 2, 16'hBEEF,   2, 1'b1, 16'hBEEF, 16'd2, 16'd7};
    tbl[9]  = '{8'h22, 1, 16'hBEEF,  -1, 1'b1, 16'hBEEF, 16'd2, 16'd8};
    tbl[10] = '{8'h22, 1, 16'hBEEF,  -1, 1'b0, 16'hBEEF, 16'd3, 16'd8};
    tbl[11] = '{8'h22, 1, 16'hBEEF,   0, 1'b1, 16'hBEEF, 16'd3, 16'd9};

    reset          = 1'b0;
    core_state     = 3'b000;
    current_pc     = 8'h00;
    flush          = 1'b0;
    mem_read_ready = 1'b0;
    mem_read_data  = 16'h0000;
    tick();
    tick();
    chk("rst_state", 32'(fetcher_state), 32'd0);
    chk("rst_valid", 32'(mem_read_valid), 32'd0);
    chk("rst_addr", 32'(mem_read_address), 32'd0);
    chk("rst_instr", 32'(instruction), 32'd0);
    chk("rst_hits", 32'(hit_count), 32'd0);
    chk("rst_misses", 32'(miss_count), 32'd0);
    reset = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_fetch(tbl[i].pc, tbl[i].lat, tbl[i].rdata, tbl[i].flush_at, missed, instr);
      chk($sformatf("v%0d_miss", i), 32'(missed), 32'(tbl[i].exp_miss));
      chk($sformatf("v%0d_instr", i), 32'(instr), 32'(tbl[i].exp_instr));
      chk($sformatf("v%0d_hits", i), 32'(hit_count), 32'(tbl[i].exp_hits));
      chk($sformatf("v%0d_misses", i), 32'(miss_count), 32'(tbl[i].exp_misses));
    end

    // Reset while a miss is outstanding.
    do_reset();
    run_fetch(8'h05, 1, 16'hA1B2, -1, missed, instr);
    run_fetch(8'h05, 1, 16'hA1B2, -1, missed, instr);
    chk("pre_rst_hit", 32'(missed), 32'd0);
    core_state = 3'b001;
    current_pc = 8'h33;
    tick();
    chk("mid_req_valid", 32'(mem_read_valid), 32'd1);
    chk("mid_req_addr", 32'(mem_read_address), 32'h33);
    reset = 1'b0;
    tick();
    reset      = 1'b1;
    core_state = 3'b000;
    chk("mid_rst_valid", 32'(mem_read_valid), 32'd0);
    chk("mid_rst_state", 32'(fetcher_state), 32'd0);
    chk("mid_rst_hits", 32'(hit_count), 32'd0);
    chk("mid_rst_misses", 32'(miss_count), 32'd0);
    tick();
    chk("mid_rst_idle_valid", 32'(mem_read_valid), 32'd0);
    run_fetch(8'h05, 2, 16'hA1B2, -1, missed, instr);
    chk("post_rst_refetch_miss", 32'(missed), 32'd1);
    chk("post_rst_misses", 32'(miss_count), 32'd1);

    // Random fetches against a transaction-level cache model.
    do_reset();
    for (int i = 0; i < 256; i++) img[i] = 16'($urandom);
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 5'd0;
    end
    eh = 16'd0;
    em = 16'd0;
    for (int n = 0; n < 400; n++) begin
      logic [7:0] pc;
      int         lat, fa, idx;
      logic       hit;
      if ($urandom_range(0, 9) == 0) begin
        flush          = 1'b1;
        mem_read_ready = 1'($urandom_range(0, 1));
        tick();
        flush          = 1'b0;
        mem_read_ready = 1'b0;
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
      end
      pc  = 8'($urandom_range(0, 31));
      lat = $urandom_range(1, 4);
      fa  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, lat) : -1;
      idx = int'(pc) % LINES;
      hit = m_valid[idx] && (m_tag[idx] == 5'(int'(pc) / LINES));
      run_fetch(pc, lat, img[pc], fa, missed, instr);
      if (hit) begin
        if (eh != 16'hFFFF) eh = eh + 16'd1;
      end else begin
        if (em != 16'hFFFF) em = em + 16'd1;
        if (fa >= 0) begin
          for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        end else begin
          m_valid[idx] = 1'b1;
          m_tag[idx]   = 5'(int'(pc) / LINES);
        end
      end
      chk($sformatf("rnd%0d_miss", n), 32'(missed), 32'(!hit));
      chk($sformatf("rnd%0d_instr", n), 32'(instr), 32'(img[pc]));
      chk($sformatf("rnd%0d_hits", n), 32'(hit_count), 32'(eh));
      chk($sformatf("rnd%0d_misses", n), 32'(miss_count), 32'(em));
    end

    // Counter saturation, preloaded near the top so the run stays short.
    do_reset();
    run_fetch(8'h01, 1, 16'h0F0F, -1, missed, instr);
    force dut.r_hit_cnt = 16'hFFFB;
    release dut.r_hit_cnt;
    eh = 16'hFFFB;
    for (int k = 0; k < 8; k++) begin
      run_fetch(8'h01, 1, 16'h0F0F, -1, missed, instr);
      if (eh != 16'hFFFF) eh = eh + 16'd1;
      chk($sformatf("sat_hit%0d", k), 32'(hit_count), 32'(eh));
    end
    force dut.r_miss_cnt = 16'hFFFF;
    release dut.r_miss_cnt;
    run_fetch(8'h02, 1, 16'h2222, -1, missed, instr);
    chk("sat_miss", 32'(miss_count), 32'hFFFF);
    chk("sat_miss_instr", 32'(instr), 32'h2222);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
